pmod_ad1_ctrl: RTL and testbench

//   Sequencer for the dual-channel PmodAD1 on JA: two AD7476A converters share CS and SCLK and drive separate data lines.

---
 rtl/pmod_ad1_pkg.sv | 15 +
 rtl/pmod_ad1_ctrl_tick_gen.sv | 30 +++
 rtl/pmod_ad1_ctrl.sv | 144 ++++++++++++++
 tb/tb_pmod_ad1_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pmod_ad1_pkg.sv
// Shared types and frame constants for the PmodAD1 (dual AD7476A) sequencer.
package pmod_ad1_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        DONE  = 2'd2,
        QUIET = 2'd3
    } state_t;

    localparam int unsigned ADC_BITS   = 12;
    localparam int unsigned LEAD_ZEROS = 4;
    localparam int unsigned FRAME_BITS = LEAD_ZEROS + ADC_BITS;

endpackage

// File: rtl/pmod_ad1_ctrl_tick_gen.sv
// Sample-rate timer: free-runs 0..DIV-1 while enabled, held at zero otherwise,
// and flags the terminal count for exactly one cycle.
module tick_gen #(
    parameter int unsigned DIV = 2500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic             at_end;

    assign at_end = (cnt == CNT_W'(DIV - 1));
    assign tick_o = en_i && at_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en_i || at_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pmod_ad1_ctrl.sv
// Conversion sequencer for the dual-channel PmodAD1: paces frames, generates
// CS/SCLK and captures both 12-bit samples with a one-cycle valid strobe.
module pmod_ad1_ctrl
    import pmod_ad1_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 3,
    parameter int unsigned SAMPLE_DIV  = 2500,
    parameter int unsigned CS_HIGH_MIN = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic                trig_i,
    input  logic                adc_d0_i,
    input  logic                adc_d1_i,
    output logic                adc_cs_n_o,
    output logic                adc_sclk_o,
    output logic [ADC_BITS-1:0] sample0_o,
    output logic [ADC_BITS-1:0] sample1_o,
    output logic                valid_o,
    output logic                busy_o,
    output logic                overrun_o
);

    localparam int unsigned EDGES  = 2 * FRAME_BITS;
    localparam int unsigned EDGE_W = $clog2(EDGES);
    localparam int unsigned HP_W   = $clog2(CLK_DIV);
    localparam int unsigned Q_W    = $clog2(CS_HIGH_MIN + 1);

    if (CLK_DIV < 2 || SAMPLE_DIV <= 32 * CLK_DIV + CS_HIGH_MIN + 2) begin : g_bad_params
        $error("pmod_ad1_ctrl: CLK_DIV must be >= 2 and SAMPLE_DIV must exceed one full frame");
    end

    state_t              state, next_state;
    logic [HP_W-1:0]     hp_cnt;
    logic [EDGE_W-1:0]   edge_cnt;
    logic [Q_W-1:0]      q_cnt;
    logic [ADC_BITS-1:0] shift0, shift1;
    logic                tick;
    logic                req;
    logic                hp_wrap;
    logic                frame_end;

    tick_gen #(
        .DIV (SAMPLE_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (en_i),
        .tick_o (tick)
    );

    assign req       = tick | trig_i;
    assign hp_wrap   = (hp_cnt == HP_W'(CLK_DIV - 1));
    assign frame_end = hp_wrap && (edge_cnt == EDGE_W'(EDGES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = CONV;
            CONV:    if (frame_end) next_state = DONE;
            DONE:    next_state = QUIET;
            QUIET:   if (q_cnt == Q_W'(CS_HIGH_MIN - 1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so CS and the strobes line up
    // with the state they describe rather than lagging it by a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_cs_n_o <= 1'b1;
            busy_o     <= 1'b0;
            valid_o    <= 1'b0;
            sample0_o  <= '0;
            sample1_o  <= '0;
        end else begin
            adc_cs_n_o <= (next_state != CONV);
            busy_o     <= (next_state != IDLE);
            valid_o    <= (next_state == DONE);
            if (next_state == DONE) begin
                sample0_o <= shift0;
                sample1_o <= shift1;
            end
        end
    end

    // The leading zeros shift out of the top, so after all 16 falls the
    // registers hold exactly D11..D0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp_cnt     <= '0;
            edge_cnt   <= '0;
            adc_sclk_o <= 1'b1;
            shift0     <= '0;
            shift1     <= '0;
        end else if (state == CONV) begin
            if (hp_wrap) begin
                hp_cnt     <= '0;
                edge_cnt   <= edge_cnt + EDGE_W'(1);
                adc_sclk_o <= ~adc_sclk_o;
                if (adc_sclk_o) begin
                    shift0 <= {shift0[ADC_BITS-2:0], adc_d0_i};
                    shift1 <= {shift1[ADC_BITS-2:0], adc_d1_i};
                end
            end else begin
                hp_cnt <= hp_cnt + HP_W'(1);
            end
        end else begin
            hp_cnt     <= '0;
            edge_cnt   <= '0;
            adc_sclk_o <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_cnt <= '0;
        end else if (state == QUIET) begin
            q_cnt <= q_cnt + Q_W'(1);
        end else begin
            q_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_o <= 1'b0;
        end else if (!en_i) begin
            overrun_o <= 1'b0;
        end else if (req && state != IDLE) begin
            overrun_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pmod_ad1_ctrl.sv
// Directed bench for pmod_ad1_ctrl with a behavioural dual AD7476A model.
module tb_pmod_ad1_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_i;
    logic        trig_i;
    logic        adc_d0_i;
    logic        adc_d1_i;
    logic        adc_cs_n_o;
    logic        adc_sclk_o;
    logic [11:0] sample0_o;
    logic [11:0] sample1_o;
    logic        valid_o;
    logic        busy_o;
    logic        overrun_o;

    pmod_ad1_ctrl #(
        .CLK_DIV     (3),
        .SAMPLE_DIV  (200),
        .CS_HIGH_MIN (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (en_i),
        .trig_i     (trig_i),
        .adc_d0_i   (adc_d0_i),
        .adc_d1_i   (adc_d1_i),
        .adc_cs_n_o (adc_cs_n_o),
        .adc_sclk_o (adc_sclk_o),
        .sample0_o  (sample0_o),
        .sample1_o  (sample1_o),
        .valid_o    (valid_o),
        .busy_o     (busy_o),
        .overrun_o  (overrun_o)
    );

    always #5 clk = ~clk;

    // ADC model: first bit out on CS fall, next bit on every SCLK fall.
    logic [11:0] v0 = '0, v1 = '0;
    logic [15:0] m0 = '0, m1 = '0;
    logic        auto_inc = 1'b0;

    always @(negedge adc_cs_n_o) begin
        m0 = {4'h0, v0};
        m1 = {4'h0, v1};
        if (auto_inc) begin
            v0 = v0 + 12'h001;
            v1 = v1 + 12'h011;
        end
    end

    always @(negedge adc_sclk_o) begin
        if (!adc_cs_n_o) begin
            m0 = {m0[14:0], 1'b0};
            m1 = {m1[14:0], 1'b0};
        end
    end

    assign adc_d0_i = m0[15];
    assign adc_d1_i = m1[15];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Window statistics
    int          low_cyc, sclk_falls, cs_falls, hi_run, last_gap;
    int          vcyc[$];
    logic [11:0] vs0[$], vs1[$];
    logic        vov[$];

    // Samples outputs at the negedge of cycles 0..ncyc-1; trig_i is raised
    // during cycles ta and tb_ (cycle 0 is the current negedge).
    task automatic run_window(input int ncyc, input int ta, input int tb_);
        logic prev_sclk, prev_cs;
        low_cyc = 0; sclk_falls = 0; cs_falls = 0; hi_run = 0; last_gap = 0;
        vcyc.delete(); vs0.delete(); vs1.delete(); vov.delete();
        prev_sclk = adc_sclk_o;
        prev_cs   = adc_cs_n_o;
        for (int k = 0; k < ncyc; k++) begin
            if (!adc_cs_n_o) low_cyc++;
            if (prev_sclk && !adc_sclk_o) sclk_falls++;
            if (prev_cs && !adc_cs_n_o) begin
                cs_falls++;
                last_gap = hi_run;
            end
            if (adc_cs_n_o) hi_run++;
            else hi_run = 0;
            if (valid_o) begin
                vcyc.push_back(k);
                vs0.push_back(sample0_o);
                vs1.push_back(sample1_o);
                vov.push_back(overrun_o);
            end
            prev_sclk = adc_sclk_o;
            prev_cs   = adc_cs_n_o;
            trig_i = (k == ta || k == tb_);
            @(negedge clk);
        end
        trig_i = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        en_i   = 1'b0;
        trig_i = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_cs_n",    32'(adc_cs_n_o), 32'd1);
        check("rst_sclk",    32'(adc_sclk_o), 32'd1);
        check("rst_valid",   32'(valid_o),    32'd0);
        check("rst_sample0", 32'(sample0_o),  32'h000);
        check("rst_sample1", 32'(sample1_o),  32'h000);
        check("rst_busy",    32'(busy_o),     32'd0);
        check("rst_overrun", 32'(overrun_o),  32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single-shot frame
        v0 = 12'hA5C; v1 = 12'h3F1;
        run_window(110, 0, -1);
        check("single_cs_low",  32'(low_cyc),    32'd96);
        check("single_falls",   32'(sclk_falls), 32'd16);
        check("single_nvalid",  32'(vcyc.size()), 32'd1);
        if (vcyc.size() >= 1) begin
            check("single_latency", 32'(vcyc[0]), 32'd97);
            check("single_s0",      32'(vs0[0]),  32'hA5C);
            check("single_s1",      32'(vs1[0]),  32'h3F1);
        end
        check("single_busy_end", 32'(busy_o), 32'd0);

        // Continuous mode: first tick at timer count 199, then every 200
        v0 = 12'h100; v1 = 12'h800; auto_inc = 1'b1;
        en_i = 1'b1;
        run_window(2100, -1, -1);
        check("cont_nvalid", 32'(vcyc.size()), 32'd10);
        if (vcyc.size() >= 1) check("cont_first", 32'(vcyc[0]), 32'd296);
        for (int i = 1; i < vcyc.size(); i++)
            check($sformatf("cont_spacing%0d", i), 32'(vcyc[i] - vcyc[i-1]), 32'd200);
        for (int i = 0; i < vcyc.size(); i++) begin
            check($sformatf("cont_s0_%0d", i), 32'(vs0[i]), 32'(12'h100 + 12'(i)));
            check($sformatf("cont_s1_%0d", i), 32'(vs1[i]), 32'(12'h800 + 12'(i * 17)));
        end
        check("cont_overrun", 32'(overrun_o), 32'd0);
        en_i = 1'b0; auto_inc = 1'b0;
        run_window(20, -1, -1);
        check("cont_idle_busy", 32'(busy_o), 32'd0);

        // Overrun: frame starts at 199; trigs at frame cycle 50 and in QUIET
        v0 = 12'h123; v1 = 12'h456;
        en_i = 1'b1;
        run_window(501, 249, 298);
        check("ovr_cs_falls", 32'(cs_falls),     32'd2);
        check("ovr_nvalid",   32'(vcyc.size()),  32'd2);
        if (vcyc.size() >= 2) begin
            check("ovr_valid0_cyc", 32'(vcyc[0]), 32'd296);
            check("ovr_valid1_cyc", 32'(vcyc[1]), 32'd496);
            check("ovr_at_valid0",  32'(vov[0]),  32'd1);
            check("ovr_s0",         32'(vs0[1]),  32'h123);
        end
        check("ovr_after_valid", 32'(overrun_o), 32'd1);
        en_i = 1'b0;
        run_window(5, -1, -1);
        check("ovr_cleared", 32'(overrun_o), 32'd0);
        check("ovr_idle",    32'(busy_o),    32'd0);

        // Reset during a frame (sclk is low at cycle 40)
        v0 = 12'h777; v1 = 12'h111;
        run_window(40, 0, -1);
        check("abort_mid_cs", 32'(adc_cs_n_o), 32'd0);
        check("abort_mid_sclk", 32'(adc_sclk_o), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_cs_n",  32'(adc_cs_n_o), 32'd1);
        check("abort_sclk",  32'(adc_sclk_o), 32'd1);
        check("abort_busy",  32'(busy_o),     32'd0);
        check("abort_valid", 32'(valid_o),    32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_window(120, -1, -1);
        check("abort_no_valid", 32'(vcyc.size()), 32'd0);
        v0 = 12'h5A3; v1 = 12'hC3E;
        run_window(110, 0, -1);
        check("post_nvalid", 32'(vcyc.size()), 32'd1);
        if (vcyc.size() >= 1) begin
            check("post_latency", 32'(vcyc[0]), 32'd97);
            check("post_s0",      32'(vs0[0]),  32'h5A3);
            check("post_s1",      32'(vs1[0]),  32'hC3E);
        end

        // Back-to-back: retrigger on the first IDLE cycle (103)
        v0 = 12'hFFF; v1 = 12'h000;
        run_window(220, 0, 103);
        check("b2b_cs_falls", 32'(cs_falls),           32'd2);
        check("b2b_gap_ok",   32'(last_gap >= 6),      32'd1);
        check("b2b_nvalid",   32'(vcyc.size()),        32'd2);
        if (vcyc.size() >= 2) begin
            check("b2b_valid1_cyc", 32'(vcyc[1]), 32'd200);
            check("b2b_s0_a", 32'(vs0[0]), 32'hFFF);
            check("b2b_s1_a", 32'(vs1[0]), 32'h000);
            check("b2b_s0_b", 32'(vs0[1]), 32'hFFF);
            check("b2b_s1_b", 32'(vs1[1]), 32'h000);
        end
        check("b2b_overrun", 32'(overrun_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
